scan_decoder: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder; successor to the fixed 4-to-16 combinational decoder.
- Adds three things the old decoder lacks: thermometer mode, an autonomous scan mode that walks the active output through all 2**IN_W lines, and selectable output polarity.
- Drives digit/row strobes (multiplexed 7-segment and LED matrix scanning) and one-hot selects in lab top levels.

---
 rtl/scan_decoder.sv | 108 ++++++++++
 tb/tb_scan_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with thermometer, autonomous scan and hold modes.
// Logical lines are kept in the register; ACTIVE_LOW inverts them on the way out.
module scan_decoder #(
  parameter int unsigned IN_W       = 4,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [IN_W-1:0]      din,
  input  logic                 load,
  output logic [(2**IN_W)-1:0] dout,
  output logic [IN_W-1:0]      idx,
  output logic                 wrap
);

  localparam int unsigned OUT_W = 2 ** IN_W;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IN_W-1:0]  IDX_MAX = {IN_W{1'b1}};

  typedef enum logic [1:0] {
    ModeDecode = 2'b00,
    ModeTherm  = 2'b01,
    ModeScan   = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  logic [IN_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] line_q, line_d;
  logic             wrap_q, wrap_d;

  function automatic logic [OUT_W-1:0] one_hot(input logic [IN_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] thermo(input logic [IN_W-1:0] sel);
    logic [OUT_W-1:0] v;
    for (int k = 0; k < OUT_W; k++) begin
      v[k] = (k <= int'(sel));
    end
    return v;
  endfunction

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    line_d = line_q;
    wrap_d = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        ModeDecode: begin
          idx_d  = din;
          cnt_d  = '0;
          line_d = one_hot(din);
        end
        ModeTherm: begin
          idx_d  = din;
          cnt_d  = '0;
          line_d = thermo(din);
        end
        ModeScan: begin
          // A load beats a coincident advance, wrap included.
          if (load) begin
            idx_d = din;
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = '0;
            wrap_d = (idx_q == IDX_MAX);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          line_d = one_hot(idx_d);
        end
        ModeHold: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      line_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
      wrap_q <= wrap_d;
    end
  end

  assign dout = line_q ^ {OUT_W{ACTIVE_LOW}};
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (16-line active-high DIV=4 and
// 8-line active-low DIV=1) share stimulus; a phase-based reference model predicts both.
module tb_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  din0;
  logic [2:0]  din1;
  logic        load;
  logic [15:0] dout0;
  logic [3:0]  idx0;
  logic        wrap0;
  logic [7:0]  dout1;
  logic [2:0]  idx1;
  logic        wrap1;

  scan_decoder #(.IN_W(4), .DIV(4), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din0), .load(load),
    .dout(dout0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(.IN_W(3), .DIV(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din1), .load(load),
    .dout(dout1), .idx(idx1), .wrap(wrap1)
  );

  typedef struct packed {
    logic [15:0] dout;
    logic [3:0]  idx;
    logic        wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int wrap_seen0 = 0;

  // Reference model: the scan position is base + (edges spent scanning) / DIV.
  int     ow[2] = '{16, 8};
  int     dv[2] = '{4, 1};
  bit     al[2] = '{1'b0, 1'b1};
  int     base[2];
  int     ph[2];
  longint ln[2];
  bit     wm[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int cur(input int d);
    return (base[d] + ph[d] / dv[d]) % ow[d];
  endfunction

  function automatic longint phys(input int d);
    longint mask;
    mask = (64'd1 << ow[d]) - 1;
    return al[d] ? (~ln[d] & mask) : ln[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      base[d] = 0;
      ph[d]   = 0;
      ln[d]   = 0;
      wm[d]   = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit e, input int md, input bit ld, input int dn);
    int ni;
    wm[d] = 1'b0;
    if (e) begin
      case (md)
        0: begin base[d] = dn; ph[d] = 0; ln[d] = 64'd1 << dn; end
        1: begin base[d] = dn; ph[d] = 0; ln[d] = (64'd1 << (dn + 1)) - 1; end
        2: begin
          if (ld) begin
            base[d] = dn;
            ph[d]   = 0;
            ln[d]   = 64'd1 << dn;
          end else begin
            ph[d]++;
            ni = cur(d);
            if ((ph[d] % dv[d]) == 0 && ni == 0) wm[d] = 1'b1;
            ln[d] = 64'd1 << ni;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One stimulus cycle: drive at the falling edge, predict, push expectations.
  task automatic cyc(input bit e, input int md, input bit ld, input int dn);
    exp_t x;
    @(negedge clk);
    en   = e;
    mode = 2'(md);
    load = ld;
    din0 = 4'(dn);
    din1 = 3'(dn);
    model_step(0, e, md, ld, dn % 16);
    model_step(1, e, md, ld, dn % 8);
    x.dout = 16'(phys(0)); x.idx = 4'(cur(0)); x.wrap = wm[0];
    q0.push_back(x);
    x.dout = 16'(phys(1)); x.idx = 4'(cur(1)); x.wrap = wm[1];
    q1.push_back(x);
  endtask

  // Monitor: every registered output update is popped and compared.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        check("dout0", dout0, x.dout);
        check("idx0", idx0, x.idx);
        check("wrap0", wrap0, x.wrap);
        if (wrap0) wrap_seen0++;
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check("dout1", dout1, x.dout);
        check("idx1", idx1, x.idx);
        check("wrap1", wrap1, x.wrap);
      end
    end
  end

  task automatic lit0(input string name, input logic [15:0] d, input logic [3:0] i,
                      input logic w);
    @(posedge clk);
    #2;
    check({name, "_dout"}, dout0, d);
    check({name, "_idx"}, idx0, i);
    check({name, "_wrap"}, wrap0, w);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    load  = 1'b0;
    din0  = '0;
    din1  = '0;
    model_reset();
    #12;
    check("rst_dout0", dout0, 16'h0000);
    check("rst_dout1", dout1, 8'hFF);
    check("rst_idx0", idx0, 0);
    check("rst_wrap0", wrap0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode and thermometer
    cyc(1, 0, 0, 5);   lit0("dec5", 16'h0020, 4'd5, 1'b0);
    cyc(1, 0, 0, 15);  lit0("dec15", 16'h8000, 4'd15, 1'b0);
    cyc(1, 0, 0, 2);
    @(posedge clk); #2; check("dec2_al", dout1, 8'hFB);
    cyc(1, 1, 0, 3);   lit0("th3", 16'h000F, 4'd3, 1'b0);
    cyc(1, 1, 0, 0);   lit0("th0", 16'h0001, 4'd0, 1'b0);
    cyc(1, 1, 0, 15);  lit0("th15", 16'hFFFF, 4'd15, 1'b0);

    // Scan from idx 14: exactly one wrap within 64 edges
    cyc(1, 0, 0, 14);
    @(posedge clk); #2;
    wrap_seen0 = 0;
    for (int i = 0; i < 64; i++) cyc(1, 2, 0, $urandom_range(0, 15));
    @(posedge clk); #2;
    check("wrap_count64", wrap_seen0, 1);

    // Load colliding with a wrap at idx 15, dwell 3
    cyc(1, 0, 0, 15);
    for (int i = 0; i < 3; i++) cyc(1, 2, 0, 0);
    cyc(1, 2, 1, 7);   lit0("load7", 16'h0080, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 2, 0, 0);
    cyc(1, 2, 0, 0);   lit0("adv8", 16'h0100, 4'd8, 1'b0);

    // Freeze by en=0 and by hold mode, mid-dwell
    cyc(1, 2, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 2, $urandom_range(0, 1), $urandom_range(0, 15));
    for (int i = 0; i < 6; i++) cyc(1, 2, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 3, $urandom_range(0, 1), $urandom_range(0, 15));
    for (int i = 0; i < 6; i++) cyc(1, 2, 0, 0);

    // Randomized mix, load rare so scans get to run
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
          $urandom_range(0, 15));
    end

    // Asynchronous reset pulse between edges, mid-scan
    for (int i = 0; i < 5; i++) cyc(1, 2, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dout1", dout1, 8'hFF);
    check("arst_idx1", idx1, 0);
    check("arst_dout0", dout0, 16'h0000);
    check("arst_idx0", idx0, 0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cyc(1, 2, 0, 0);

    @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
